// File: rtl/frequency_pkg.sv
// Shared helpers for the elevator tick-clock generator.
package frequency_pkg;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input longint unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frequency_if.sv
// Board-side signals of the tick-clock generator: call buttons, motion flag and the tick.
interface frequency_if;
  logic button1;
  logic button2;
  logic button3;
  logic moving;
  logic clk;

  modport master (
    output button1,
    output button2,
    output button3,
    output moving,
    input  clk
  );

  modport slave (
    input  button1,
    input  button2,
    input  button3,
    input  moving,
    output clk
  );
endinterface

// File: rtl/frequency_press_sync.sv
// Catches arbitrarily short button presses, brings them into clk_50 and emits one pulse each.
module press_sync (
  input  logic clk_50,
  input  logic rst_n,
  input  logic press_any,
  output logic press_evt
);

  logic cap_q;
  logic sync1_q;
  logic sync2_q;
  logic sync3_q;

  // Asynchronous set so sub-cycle pulses are not lost; cleared once the sync chain has seen it.
  always_ff @(posedge clk_50 or negedge rst_n or posedge press_any) begin
    if (!rst_n) begin
      cap_q <= 1'b0;
    end else if (press_any) begin
      cap_q <= 1'b1;
    end else if (sync2_q) begin
      cap_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= cap_q;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign press_evt = sync2_q & ~sync3_q;

endmodule

// File: rtl/frequency.sv
// Gated, glitch-free divided tick clock: runs while moving or for a hold window after a press.
module frequency
  import frequency_pkg::*;
#(
  parameter int unsigned clk_frequency = 25_000_000,
  parameter int unsigned HOLD_PERIODS  = 4
) (
  input  logic        clk_50,
  input  logic        rst_n,
  frequency_if.slave  bus
);

  localparam longint unsigned HoldLoad = longint'(HOLD_PERIODS) * 2 * longint'(clk_frequency);
  localparam int unsigned     HoldW    = cnt_width(HoldLoad + 1);
  localparam int unsigned     DivW     = cnt_width(longint'(clk_frequency));
  localparam logic [DivW-1:0] DivLast  = DivW'(clk_frequency - 1);

  logic             press_any;
  logic             press_evt;
  logic             en;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             clk_q, clk_d;

  assign press_any = ~bus.button1 | ~bus.button2 | ~bus.button3;

  press_sync u_press_sync (
    .clk_50    (clk_50),
    .rst_n     (rst_n),
    .press_any (press_any),
    .press_evt (press_evt)
  );

  always_comb begin
    hold_d = hold_q;
    if (press_evt) begin
      hold_d = HoldW'(HoldLoad);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HoldW'(1);
    end
  end

  assign en = bus.moving | (hold_q != '0);

  // A high half-period always completes even if en drops, so no runt highs reach the FSMs.
  always_comb begin
    div_d = div_q;
    clk_d = clk_q;
    if (en || clk_q) begin
      if (div_q == DivLast) begin
        div_d = '0;
        clk_d = ~clk_q;
      end else begin
        div_d = div_q + DivW'(1);
      end
    end else begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      div_q  <= '0;
      clk_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      div_q  <= div_d;
      clk_q  <= clk_d;
    end
  end

  assign bus.clk = clk_q;

endmodule

// File: tb/tb_frequency.sv
// Self-checking bench: expected tick-clock transitions are queued per scenario and matched live.
`timescale 1ns/1ps
module tb_frequency;

  typedef struct {
    int   cyc;
    logic level;
  } edge_t;

  logic clk_50 = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic clk_prev = 1'b0;
  edge_t exp_q[$];

  frequency_if bus ();

  frequency #(
    .clk_frequency (10),
    .HOLD_PERIODS  (4)
  ) dut (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) cyc <= cyc + 1;

  // Every clk transition must match the next queued expectation (cycle and level).
  always @(negedge clk_50) begin
    edge_t e;
    if (bus.clk !== clk_prev) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_edge: clk went to %0b at cycle %0d, required no edge",
                 bus.clk, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc == cyc && e.level === bus.clk) n_pass++;
        else $display("FAIL clk_edge: got level %0b at cycle %0d, required level %0b at cycle %0d",
                      bus.clk, cyc, e.level, e.cyc);
      end
    end
    clk_prev = bus.clk;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  task automatic push_edge(input int c, input logic lvl);
    edge_t e;
    e.cyc   = c;
    e.level = lvl;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk_50);
  endtask

  task automatic check_drained(input string name);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL %s: %0d clk edges still outstanding (first at cycle %0d), required 0",
               name, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic check_clk_low(input string name);
    n_total++;
    if (bus.clk === 1'b0) n_pass++;
    else $display("FAIL %s: clk=%0b at cycle %0d, required 0", name, bus.clk, cyc);
  endtask

  task automatic test_reset();
    int c0;
    rst_n = 1'b0;
    bus.button1 = 1'b1;
    bus.button2 = 1'b1;
    bus.button3 = 1'b1;
    bus.moving  = 1'b0;
    repeat (5) @(negedge clk_50);
    check_clk_low("reset_active");
    rst_n = 1'b1;
    c0 = cyc;
    wait_cyc(c0 + 200);
    check_clk_low("reset_idle");
    check_drained("reset_quiet");
  endtask

  task automatic test_pulse_press();
    int c0;
    int evt_n;
    int evt_cyc;
    @(negedge clk_50);
    c0 = cyc;
    evt_n = 0;
    evt_cyc = -1;
    for (int k = 0; k < 4; k++) begin
      push_edge(c0 + 13 + 20 * k, 1'b1);
      push_edge(c0 + 23 + 20 * k, 1'b0);
    end
    #2 bus.button1 = 1'b0;
    #10 bus.button1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_50);
      if (dut.press_evt === 1'b1) begin
        evt_n++;
        if (evt_cyc < 0) evt_cyc = cyc;
      end
    end
    n_total++;
    if (evt_n == 1) n_pass++;
    else $display("FAIL pulse_evt_count: %0d press events, required 1", evt_n);
    n_total++;
    if (evt_cyc >= 0 && evt_cyc <= c0 + 3) n_pass++;
    else $display("FAIL pulse_evt_latency: event at cycle %0d, required by cycle %0d",
                  evt_cyc, c0 + 3);
    wait_cyc(c0 + 200);
    check_clk_low("pulse_parked");
    check_drained("pulse_periods");
  endtask

  task automatic test_moving();
    int c0;
    c0 = cyc;
    for (int k = 0; k < 4; k++) push_edge(c0 + 10 + 20 * k, 1'b1);
    for (int k = 0; k < 3; k++) push_edge(c0 + 20 + 20 * k, 1'b0);
    // Order queue chronologically: rise/fall interleaved.
    exp_q.sort() with (item.cyc);
    bus.moving = 1'b1;
    wait_cyc(c0 + 75);
    check_drained("moving_run");
  endtask

  task automatic test_stop_high();
    int c0;
    c0 = cyc;
    n_total++;
    if (bus.clk === 1'b1) n_pass++;
    else $display("FAIL stop_precondition: clk=%0b, required 1", bus.clk);
    push_edge(c0 + 5, 1'b0);
    bus.moving = 1'b0;
    wait_cyc(c0 + 150);
    check_clk_low("stop_parked");
    check_drained("stop_full_high");
  endtask

  task automatic test_press_while_moving();
    int c0;
    c0 = cyc;
    push_edge(c0 + 10, 1'b1);
    push_edge(c0 + 20, 1'b0);
    for (int k = 0; k < 4; k++) begin
      push_edge(c0 + 30 + 20 * k, 1'b1);
      push_edge(c0 + 40 + 20 * k, 1'b0);
    end
    bus.moving = 1'b1;
    wait_cyc(c0 + 25);
    bus.button2 = 1'b0;
    wait_cyc(c0 + 27);
    bus.button2 = 1'b1;
    wait_cyc(c0 + 30);
    bus.moving = 1'b0;
    wait_cyc(c0 + 250);
    check_clk_low("retrigger_parked");
    check_drained("retrigger_periods");
  endtask

  task automatic test_held_button();
    int c0;
    int evt_n;
    c0 = cyc;
    evt_n = 0;
    for (int k = 0; k < 4; k++) begin
      push_edge(c0 + 13 + 20 * k, 1'b1);
      push_edge(c0 + 23 + 20 * k, 1'b0);
    end
    bus.button3 = 1'b0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk_50);
      if (dut.press_evt === 1'b1) evt_n++;
      if (i == 99) bus.button3 = 1'b1;
    end
    n_total++;
    if (evt_n == 1) n_pass++;
    else $display("FAIL held_evt_count: %0d press events, required 1", evt_n);
    wait_cyc(c0 + 200);
    check_drained("held_periods");
  endtask

  task automatic test_async_reset();
    int c0;
    c0 = cyc;
    push_edge(c0 + 10, 1'b1);
    bus.moving = 1'b1;
    wait_cyc(c0 + 15);
    push_edge(c0 + 16, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check_clk_low("async_reset_immediate");
    bus.moving = 1'b0;
    repeat (3) @(negedge clk_50);
    rst_n = 1'b1;
    wait_cyc(c0 + 70);
    check_clk_low("async_reset_idle");
    check_drained("async_reset_edges");
  endtask

  initial begin
    test_reset();
    test_pulse_press();
    test_moving();
    test_stop_high();
    test_press_while_moving();
    test_held_button();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
